// File: rtl/bcedn_frame_feeder_if.sv
// Source stream into the B-CEDNet frame feeder: valid/ready word handshake.
// master is the upstream word source, slave is the feeder.
interface bcedn_frame_feeder_if #(
    parameter int unsigned DATA_WIDTH = 512
) ();
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bcedn_frame_feeder.sv
// Host-side feeder: pulses start, streams one frame of words into the accelerator
// input FIFO under almost-full backpressure, then waits for done while counting results.
module bcedn_frame_feeder #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned FRAME_WORDS = 1024,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned START_LEAD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    bcedn_frame_feeder_if.slave   src,
    input  logic                  fifo_wfull,
    input  logic                  done,
    input  logic                  out_en,
    output logic                  start,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_en,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  out_beats,
    output logic                  err
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLead,
        StStream,
        StWaitDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] FrameWords = CNT_WIDTH'(FRAME_WORDS);
    // START itself supplies one cycle of the lead, so LEAD lasts START_LEAD-1 cycles.
    localparam logic [3:0]           LeadInit   = 4'(START_LEAD - 1);

    state_e                state_q, state_d;
    logic [3:0]            lead_q, lead_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  out_beats_q, out_beats_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  start_q, start_d;
    logic                  in_en_q, in_en_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign src.s_ready  = (state_q == StStream) && !fifo_wfull && (word_cnt_q < FrameWords);
    assign accept       = src.s_valid && src.s_ready;
    assign word_cnt_inc = word_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        lead_d      = lead_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        out_beats_d = out_beats_q;
        err_d       = err_q;
        start_d     = 1'b0;
        in_en_d     = accept;
        data_d      = accept ? src.s_data : data_q;

        if (out_en) begin
            if (state_q == StIdle) begin
                err_d = 1'b1;
            end else if (out_beats_q != {CNT_WIDTH{1'b1}}) begin
                out_beats_d = out_beats_q + CNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StStart;
                    start_d = 1'b1;
                end
            end
            StStart: begin
                // Clear for the new frame but keep a beat arriving in this very cycle.
                out_beats_d = CNT_WIDTH'(out_en);
                word_cnt_d  = '0;
                lead_d      = LeadInit;
                state_d     = (START_LEAD > 1) ? StLead : StStream;
            end
            StLead: begin
                lead_d = lead_q - 4'd1;
                if (lead_q == 4'd1) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == FrameWords) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: state_d = state_q;
            default:    state_d = StIdle;
        endcase

        // An early done is flagged but still closes the frame.
        if (done && (state_q != StIdle)) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            state_d     = StIdle;
            if (state_q != StWaitDone) begin
                err_d = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            lead_q      <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            out_beats_q <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            in_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lead_q      <= lead_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            out_beats_q <= out_beats_d;
            data_q      <= data_d;
            start_q     <= start_d;
            in_en_q     <= in_en_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign start     = start_q;
    assign data_in   = data_q;
    assign in_en     = in_en_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign out_beats = out_beats_q;
    assign err       = err_q;

endmodule
